// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder family.
// State encodings are plain 2-bit constants so legacy code can compare against them directly.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit combinational full adder, shared by the serial adder and subtractor variants.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands captured on start, summed LSB-first through
// one carry flip-flop, {carry,sum} registered on the last bit with a one-cycle valid.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             c_q,      c_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_shifted;

    full_adder_bit u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New bit enters at the MSB so after WIDTH shifts the LSB-first stream is in order.
    assign sum_shifted = {fa_s, sum_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        carry_d  = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_shifted;
                c_d      = fa_co;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_shifted;
                    carry_d = fa_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign valid = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed table and corner sequences on a 4-bit instance,
// then randomized traffic on 4-bit and 8-bit instances against an arithmetic model.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start4, cin4, busy4, valid4, carry4;
    logic [3:0] a4, b4, sum4;

    logic       start8, cin8, busy8, valid8, carry8;
    logic [7:0] a8, b8, sum8;

    int checks;
    int failures;

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .valid (valid4),
        .sum   (sum4),
        .carry (carry4)
    );

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .valid (valid8),
        .sum   (sum8),
        .carry (carry8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op on the 4-bit instance (assumed idle) and checks latency, busy span and result.
    task automatic run_op4(input string name, input logic [3:0] ia, input logic [3:0] ib,
                           input logic icin, input logic [3:0] esum, input logic ecarry);
        int lat;
        int busy_cnt;
        a4 = ia; b4 = ib; cin4 = icin; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = ~ia; b4 = ~ib; cin4 = ~icin;
        lat = 0;
        busy_cnt = 0;
        forever begin
            if (busy4) busy_cnt++;
            if (valid4 || lat >= 20) break;
            tick();
            lat++;
        end
        chk({name, "_latency"}, lat, 4);
        chk({name, "_sum"}, sum4, esum);
        chk({name, "_carry"}, carry4, ecarry);
        tick();
        chk({name, "_valid_width"}, valid4, 1'b0);
        chk({name, "_busy_span"}, busy_cnt, 5);
        chk({name, "_hold"}, {carry4, sum4}, {ecarry, esum});
    endtask

    task automatic wait_valid4(output int n);
        n = 0;
        while (!valid4 && n < 30) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       carry;
    } vec_t;

    typedef struct {
        logic [8:0] res;
        int         due;
    } exp_t;

    initial begin
        vec_t vecs[6];
        exp_t q4[$];
        exp_t q8[$];
        int   n;
        int   n2;
        int   k;
        int   free4, free8, acc4, acc8;
        logic [8:0] last4, last8;
        logic seen;

        checks = 0;
        failures = 0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

        // Reset held with start asserted: everything stays at zero.
        rst_n = 1'b0; start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_busy", busy4, 1'b0);
            chk("rst_valid", valid4, 1'b0);
            chk("rst_sum", sum4, 4'h0);
            chk("rst_carry", carry4, 1'b0);
        end
        start4 = 1'b0;
        rst_n = 1'b1;
        tick();

        vecs[0] = '{"add_9_5",     4'd9, 4'd5, 1'b0, 4'b1110, 1'b0};
        vecs[1] = '{"wrap_F_1",    4'hF, 4'h1, 1'b0, 4'h0,    1'b1};
        vecs[2] = '{"max_FF_c1",   4'hF, 4'hF, 1'b1, 4'hF,    1'b1};
        vecs[3] = '{"zero",        4'h0, 4'h0, 1'b0, 4'h0,    1'b0};
        vecs[4] = '{"add_7_8_c1",  4'h7, 4'h8, 1'b1, 4'h0,    1'b1};
        vecs[5] = '{"add_A_5",     4'hA, 4'h5, 1'b0, 4'hF,    1'b0};
        for (int i = 0; i < 6; i++)
            run_op4(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].carry);

        // Start held through RUN with new operands: ignored until the next IDLE.
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0; start4 = 1'b1;
        tick();
        a4 = 4'd8; b4 = 4'd8;
        wait_valid4(n);
        chk("hold_start_latency", n, 4);
        chk("hold_start_sum", sum4, 4'd7);
        chk("hold_start_carry", carry4, 1'b0);
        tick();
        wait_valid4(n2);
        start4 = 1'b0;
        chk("b2b_gap", n2 + 1, 6);
        chk("b2b_sum", sum4, 4'd0);
        chk("b2b_carry", carry4, 1'b1);
        tick();

        // Async reset in the middle of RUN abandons the op.
        a4 = 4'd6; b4 = 4'd7; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", sum4, 4'h0);
        chk("midrst_carry", carry4, 1'b0);
        chk("midrst_busy", busy4, 1'b0);
        chk("midrst_valid", valid4, 1'b0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid4) seen = 1'b1;
        end
        chk("midrst_no_valid", seen, 1'b0);
        run_op4("after_rst_2_2", 4'd2, 4'd2, 1'b0, 4'd4, 1'b0);

        // Randomized traffic on both widths against a+b+cin with modelled acceptance timing.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        k = 0; free4 = 0; free8 = 0; acc4 = 0; acc8 = 0;
        last4 = '0; last8 = '0;
        while ((acc4 < 1000 || acc8 < 1000 || q4.size() > 0 || q8.size() > 0) && k < 40000) begin
            start4 = (acc4 < 1000) && ($urandom_range(0, 2) == 0);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            start8 = (acc8 < 1000) && ($urandom_range(0, 2) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk);
            if (start4 && k >= free4) begin
                q4.push_back('{9'(a4) + 9'(b4) + 9'(cin4), k + 4});
                free4 = k + 6;
                acc4++;
            end
            if (start8 && k >= free8) begin
                q8.push_back('{9'(a8) + 9'(b8) + 9'(cin8), k + 8});
                free8 = k + 10;
                acc8++;
            end
            #1;
            if (q4.size() > 0 && q4[0].due == k) begin
                chk("rnd4_valid", valid4, 1'b1);
                chk("rnd4_result", {carry4, sum4}, q4[0].res);
                last4 = q4[0].res;
                void'(q4.pop_front());
            end else begin
                chk("rnd4_valid", valid4, 1'b0);
                chk("rnd4_hold", {carry4, sum4}, last4);
            end
            if (q8.size() > 0 && q8[0].due == k) begin
                chk("rnd8_valid", valid8, 1'b1);
                chk("rnd8_result", {carry8, sum8}, q8[0].res);
                last8 = q8[0].res;
                void'(q8.pop_front());
            end else begin
                chk("rnd8_valid", valid8, 1'b0);
                chk("rnd8_hold", {carry8, sum8}, last8);
            end
            k++;
        end
        chk("rnd_completed", (k < 40000), 1'b1);
        start4 = 1'b0;
        start8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
